mips_multicycle_ctrl: RTL and testbench

Multi-cycle control FSM that sequences the MIPS datapath: shared memory port, ALU, register file and PC.
- Decodes the same opcode set as the single-cycle decoder: R-type, addi, li, lw, sw, j, beq.
- Issues per-state Moore control strobes.
- Stalls on a memory ready handshake, traps on illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/mips_multicycle_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Control FSM for a multi-cycle MIPS datapath. It sequences the shared memory
// port, the ALU, the register file and the PC for R-type, addi, li, lw, sw,
// j and beq. Control strobes are Moore outputs decoded from the current
// state. The exceptions are IRWrite/PCWrite in FETCH, which follow mem_ready,
// and pc_en, which folds in the ALU Zero flag.
//
// Memory states (FETCH, MEM_READ, MEM_WRITE) stall on mem_ready. If a memory
// state waits too long, or DECODE sees an unknown opcode, the FSM parks in
// TRAP with a sticky error code until reset.
//
// Optional feature: define BNE_EN to add the bne opcode (000101) and the BNE
// state (14). When BNE_EN is not defined, bne is an illegal opcode.
//
// Parameters:
//   WAIT_MAX  : longest run of mem_ready=0 cycles a memory state tolerates
//               before trapping (1..255)
//   CNT_W     : width of the retired-instruction counter
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   opcode[5:0]          : IR[31:26]
//   Zero                 : ALU zero flag
//   mem_ready            : memory finishes the current access this cycle
//   PCWrite/PCWriteCond  : unconditional / conditional PC load
//   pc_en                : final PC load enable
//   IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
//   ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0] : datapath controls
//   state[3:0]           : current state encoding
//   err, err_code[1:0]   : sticky trap flag / cause (01 illegal, 10 timeout)
//   instr_count[CNT_W-1:0] : retired instructions (wraps)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             pc_en,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_R_EXEC    = 4'd7;
  localparam logic [3:0] S_R_WB      = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JUMP      = 4'd10;
  localparam logic [3:0] S_ADDI_EXEC = 4'd11;
  localparam logic [3:0] S_ADDI_WB   = 4'd12;
  localparam logic [3:0] S_TRAP      = 4'd13;
`ifdef BNE_EN
  localparam logic [3:0] S_BNE       = 4'd14;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LI    = 6'b100111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  logic [3:0]       state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic mem_state;
  logic mem_stall;
  logic mem_timeout;
  logic retire;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      err_q         <= 1'b0;
      err_code_q    <= 2'b00;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      instr_count_q <= instr_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // The wait counter only runs while a memory state is stalled. Every way out
  // of a memory state either completes (mem_ready=1) or traps, so the counter
  // is already zero whenever a memory state is entered.
  assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                       (state_q == S_MEM_WRITE);
  assign mem_stall   = mem_state && !mem_ready;
  assign mem_timeout = mem_stall && (wait_q == 8'(WAIT_MAX));

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    wait_d     = (mem_stall && !mem_timeout) ? 8'(wait_q + 8'd1) : 8'd0;

    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (mem_timeout) begin
          state_d    = S_TRAP;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:       state_d = S_R_EXEC;
          OP_ADDI, OP_LI: state_d = S_ADDI_EXEC;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_J:           state_d = S_JUMP;
          OP_BEQ:         state_d = S_BRANCH;
`ifdef BNE_EN
          OP_BNE:         state_d = S_BNE;
`endif
          default: begin
            state_d    = S_TRAP;
            err_code_d = ERR_ILLEGAL;
          end
        endcase
      end
      // The IR still holds the instruction, so the opcode picks lw or sw here.
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready)        state_d = S_MEM_WB;
        else if (mem_timeout) begin
          state_d    = S_TRAP;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_MEM_WB:  state_d = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready)        state_d = S_FETCH;
        else if (mem_timeout) begin
          state_d    = S_TRAP;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
`ifdef BNE_EN
      S_BNE:       state_d = S_FETCH;
`endif
      S_TRAP:      state_d = S_TRAP;
      default: begin
        state_d    = S_TRAP;
        err_code_d = ERR_ILLEGAL;
      end
    endcase

    err_d = err_q || (state_d == S_TRAP);
  end

  // An instruction retires when a completing state hands back to FETCH. A
  // trap never reaches FETCH, so it never counts.
  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
`ifdef BNE_EN
        S_BNE: retire = 1'b1;
`endif
        default: retire = 1'b0;
      endcase
    end
    instr_count_d = instr_count_q + CNT_W'(retire);
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // Strobes are forced low while reset is high. An instruction that is
  // interrupted by reset then stops driving the datapath in that same cycle.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    pc_en       = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE:    ALUSrcB = 2'b11;
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_R_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_R_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
`ifdef BNE_EN
        S_BRANCH, S_BNE: begin
`else
        S_BRANCH: begin
`endif
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCSource    = 2'b01;
          PCWriteCond = 1'b1;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_ADDI_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_ADDI_WB:   RegWrite = 1'b1;
        default: ;
      endcase
    end

`ifdef BNE_EN
    // bne takes the branch on a non-zero compare.
    if (state_q == S_BNE) pc_en = PCWrite | (PCWriteCond & ~Zero);
    else                  pc_en = PCWrite | (PCWriteCond & Zero);
`else
    pc_en = PCWrite | (PCWriteCond & Zero);
`endif
  end

  assign state       = state_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
`define CHK(tag, obs, exp) check(tag, 32'(obs), 32'(exp))

module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        Zero;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite;
    logic        RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] instr_count;
    logic [16:0] strobes;

    int compared   = 0;
    int mismatched = 0;

    mips_multicycle_ctrl #(.WAIT_MAX(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .pc_en(pc_en), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .state(state), .err(err),
        .err_code(err_code), .instr_count(instr_count)
    );

    assign strobes = {PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite,
                      RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; opcode = 6'b000000; Zero = 1'b0; mem_ready = 1'b1;

        tick(); tick(); #1;
        `CHK("rst_state", state, 0);
        `CHK("rst_err", err, 0);
        `CHK("rst_err_code", err_code, 0);
        `CHK("rst_count", instr_count, 0);
        `CHK("rst_strobes", strobes, 0);
        $display("txn reset: state=%0d count=%0d", state, instr_count);

        reset = 1'b0;
        tick(); #1;
        `CHK("r_fetch", state, 1);
        `CHK("r_fetch_memread", MemRead, 1);
        `CHK("r_fetch_irwrite", IRWrite, 1);
        `CHK("r_fetch_alusrcb", ALUSrcB, 2'b01);
        tick(); #1;
        `CHK("r_decode", state, 2);
        `CHK("r_decode_alusrcb", ALUSrcB, 2'b11);
        `CHK("r_decode_regwrite", RegWrite, 0);
        tick(); #1;
        `CHK("r_exec", state, 7);
        `CHK("r_exec_aluop", ALUOp, 2'b10);
        `CHK("r_exec_regwrite", RegWrite, 0);
        tick(); #1;
        `CHK("r_wb", state, 8);
        `CHK("r_wb_regwrite", RegWrite, 1);
        `CHK("r_wb_regdst", RegDst, 1);
        tick(); #1;
        `CHK("r_back_fetch", state, 1);
        `CHK("r_count", instr_count, 1);
        $display("txn rtype: count=%0d", instr_count);

        opcode = 6'b100011;
        tick(); #1; `CHK("lw_decode", state, 2);
        tick(); #1; `CHK("lw_addr", state, 3);
        `CHK("lw_addr_alusrcb", ALUSrcB, 2'b10);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            compared++;
            if (state !== 4'd4) begin
                mismatched++;
                $error("FAIL lw_read_stall: observed %0h expected 4", state);
            end
        end
        `CHK("lw_read_iord", IorD, 1);
        `CHK("lw_read_memread", MemRead, 1);
        tick(); mem_ready = 1'b1; #1;
        `CHK("lw_read_last", state, 4);
        tick(); #1;
        `CHK("lw_wb", state, 5);
        `CHK("lw_wb_regwrite", RegWrite, 1);
        `CHK("lw_wb_memtoreg", MemtoReg, 1);
        tick(); #1;
        `CHK("lw_back_fetch", state, 1);
        `CHK("lw_count", instr_count, 2);
        $display("txn lw: count=%0d", instr_count);

        opcode = 6'b000100;
        tick(); tick(); Zero = 1'b1; #1;
        `CHK("beq1_state", state, 9);
        `CHK("beq1_pc_en", pc_en, 1);
        `CHK("beq1_pcsource", PCSource, 2'b01);
        `CHK("beq1_aluop", ALUOp, 2'b01);
        tick(); #1;
        `CHK("beq1_fetch", state, 1);
        `CHK("beq1_count", instr_count, 3);
        tick(); tick(); Zero = 1'b0; #1;
        `CHK("beq2_state", state, 9);
        `CHK("beq2_pc_en", pc_en, 0);
        `CHK("beq2_pcwritecond", PCWriteCond, 1);
        tick(); #1;
        `CHK("beq2_fetch", state, 1);
        `CHK("beq2_count", instr_count, 4);
        $display("txn beq x2: count=%0d", instr_count);

        opcode = 6'b000010;
        tick(); tick(); #1;
        `CHK("j_state", state, 10);
        `CHK("j_pc_en", pc_en, 1);
        `CHK("j_pcsource", PCSource, 2'b10);
        tick(); #1;
        `CHK("j_count", instr_count, 5);
        $display("txn j: count=%0d", instr_count);

        opcode = 6'b001000;
        tick(); tick(); #1; `CHK("addi_exec", state, 11);
        tick(); #1;
        `CHK("addi_wb", state, 12);
        `CHK("addi_wb_regwrite", RegWrite, 1);
        `CHK("addi_wb_regdst", RegDst, 0);
        opcode = 6'b100111;
        tick(); #1; `CHK("addi_fetch", state, 1);
        tick(); tick(); #1; `CHK("li_exec", state, 11);
        tick(); tick(); #1;
        `CHK("li_fetch", state, 1);
        `CHK("li_count", instr_count, 7);
        $display("txn addi+li: count=%0d", instr_count);

        opcode = 6'b101011;
        tick(); tick(); #1; `CHK("sw_addr", state, 3);
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick(); #1;
            compared++;
            if (state !== 4'd6) begin
                mismatched++;
                $error("FAIL sw_stall: observed %0h expected 6", state);
            end
        end
        `CHK("sw_memwrite", MemWrite, 1);
        tick(); #1;
        `CHK("sw_trap_state", state, 13);
        `CHK("sw_trap_err", err, 1);
        `CHK("sw_trap_code", err_code, 2'b10);
        `CHK("sw_trap_count", instr_count, 7);
        $display("txn sw timeout: state=%0d err_code=%0d", state, err_code);

        reset = 1'b1; tick(); #1;
        `CHK("rst2_state", state, 0);
        `CHK("rst2_err", err, 0);
        `CHK("rst2_count", instr_count, 0);
        reset = 1'b0; mem_ready = 1'b1;
        tick(); #1; `CHK("rst2_fetch", state, 1);

        tick(); tick(); #1; `CHK("sw2_addr", state, 3);
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(); #1;
            compared++;
            if (state !== 4'd6) begin
                mismatched++;
                $error("FAIL sw2_stall: observed %0h expected 6", state);
            end
        end
        tick(); mem_ready = 1'b1; #1;
        `CHK("sw2_last", state, 6);
        tick(); #1;
        `CHK("sw2_fetch", state, 1);
        `CHK("sw2_err", err, 0);
        `CHK("sw2_count", instr_count, 1);
        $display("txn sw ready at limit: count=%0d", instr_count);

        opcode = 6'b111111; Zero = 1'b1;
        tick(); tick(); #1;
        `CHK("ill_state", state, 13);
        `CHK("ill_err", err, 1);
        `CHK("ill_code", err_code, 2'b01);
        `CHK("ill_strobes", strobes, 0);
        for (int i = 0; i < 20; i++) tick();
        #1;
        `CHK("ill_held", state, 13);
        `CHK("ill_held_err", err, 1);
        reset = 1'b1; tick(); #1;
        `CHK("ill_rst_err", err, 0);
        `CHK("ill_rst_code", err_code, 0);
        $display("txn illegal opcode: trapped and cleared");

        reset = 1'b0; opcode = 6'b000101; Zero = 1'b0;
        tick(); tick(); tick(); #1;
`ifdef BNE_EN
        `CHK("bne_state", state, 14);
        `CHK("bne_pc_en", pc_en, 1);
        tick(); #1;
        `CHK("bne_count", instr_count, 1);
`else
        `CHK("bne_state", state, 13);
        `CHK("bne_code", err_code, 2'b01);
`endif
        $display("txn bne: state=%0d err_code=%0d", state, err_code);

        reset = 1'b1; tick(); reset = 1'b0; opcode = 6'b100011;
        tick(); tick(); tick(); tick(); #1;
        `CHK("mid_read", state, 4);
        reset = 1'b1; tick(); #1;
        `CHK("mid_rst_state", state, 0);
        `CHK("mid_rst_memread", MemRead, 0);
        `CHK("mid_rst_count", instr_count, 0);
        $display("txn mid-instruction reset: state=%0d", state);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
